// File: rtl/proc_ctrl_pkg.sv
// Shared types and constants for the process-control sequencing blocks.
package proc_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam int          NUM_CH   = 4;
    localparam logic [2:0]  SEL_NONE = 3'd0;

    // Decoder select code for a channel: channel i is presented as i+1, 0 means none.
    function automatic logic [2:0] sel_code(input logic [1:0] idx);
        return {1'b0, idx} + 3'd1;
    endfunction

endpackage

// File: rtl/button_turn_scheduler_rr_pick4.sv
// Combinational four-way round-robin picker: first requester strictly after last.
module rr_pick4
    import proc_ctrl_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic       valid,
    output logic [1:0] idx
);

    logic [1:0] start;
    logic [3:0] rot;

    assign start = last + 2'd1;

    // rot[k] is the request of the channel k positions after the starting channel.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_rot
            assign rot[gi] = req[start + 2'(gi)];
        end
    endgenerate

    always_comb begin
        valid = |rot;
        idx   = start;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = start + 2'(k);
            end
        end
    end

endmodule

// File: rtl/button_turn_scheduler.sv
// Round-robin turn scheduler driving the button decoder select and registered button bus.
module button_turn_scheduler
    import proc_ctrl_pkg::*;
#(
    parameter int TURN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] done,
    input  logic [2:0] buttons,
    output logic [2:0] select,
    output logic [3:0] grant,
    output logic [2:0] btn_out,
    output logic       busy,
    output logic       timeout
);

    localparam logic [7:0] TURN_LOAD = 8'(TURN_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [1:0] last_reg, last_next;
    logic [7:0] cnt_reg, cnt_next;
    logic [3:0] grant_reg, grant_next;
    logic [2:0] select_reg, select_next;
    logic [2:0] btn_reg, btn_next;
    logic       busy_reg, busy_next;
    logic       timeout_reg, timeout_next;

    logic       pick_valid;
    logic [1:0] pick_idx;

    rr_pick4 u_pick (
        .req   (req),
        .last  (last_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            last_reg    <= 2'd3;
            cnt_reg     <= 8'd0;
            grant_reg   <= 4'd0;
            select_reg  <= SEL_NONE;
            btn_reg     <= 3'd0;
            busy_reg    <= 1'b0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            last_reg    <= last_next;
            cnt_reg     <= cnt_next;
            grant_reg   <= grant_next;
            select_reg  <= select_next;
            btn_reg     <= btn_next;
            busy_reg    <= busy_next;
            timeout_reg <= timeout_next;
        end
    end

    // While granted, last_reg already holds the current holder's index.
    always_comb begin
        state_next   = state_reg;
        last_next    = last_reg;
        cnt_next     = cnt_reg;
        grant_next   = grant_reg;
        select_next  = select_reg;
        btn_next     = btn_reg;
        busy_next    = busy_reg;
        timeout_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    grant_next  = 4'b0001 << pick_idx;
                    select_next = sel_code(pick_idx);
                    last_next   = pick_idx;
                    cnt_next    = TURN_LOAD;
                    busy_next   = 1'b1;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                if (done[last_reg] || !req[last_reg] || (cnt_reg == 8'd0)) begin
                    // Only a turn that was neither completed nor withdrawn counts as a timeout.
                    timeout_next = !done[last_reg] && req[last_reg];
                    grant_next   = 4'd0;
                    select_next  = SEL_NONE;
                    btn_next     = 3'd0;
                    busy_next    = 1'b0;
                    state_next   = GAP;
                end else begin
                    cnt_next = cnt_reg - 8'd1;
                    btn_next = buttons;
                end
            end
            GAP: begin
                state_next = IDLE;
            end
            default: begin
                state_next  = IDLE;
                grant_next  = 4'd0;
                select_next = SEL_NONE;
                btn_next    = 3'd0;
                busy_next   = 1'b0;
            end
        endcase
    end

    assign select  = select_reg;
    assign grant   = grant_reg;
    assign btn_out = btn_reg;
    assign busy    = busy_reg;
    assign timeout = timeout_reg;

endmodule

// File: tb/tb_button_turn_scheduler.sv
// Directed bench for button_turn_scheduler (TURN_CYCLES=4) and its round-robin picker.
module tb_button_turn_scheduler;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] done;
    logic [2:0] buttons;
    logic [2:0] select;
    logic [3:0] grant;
    logic [2:0] btn_out;
    logic       busy;
    logic       timeout;

    logic [3:0] pk_req;
    logic [1:0] pk_last;
    logic       pk_valid;
    logic [1:0] pk_idx;

    int errors = 0;
    int checks = 0;

    button_turn_scheduler #(.TURN_CYCLES(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .buttons (buttons),
        .select  (select),
        .grant   (grant),
        .btn_out (btn_out),
        .busy    (busy),
        .timeout (timeout)
    );

    rr_pick4 u_pick (
        .req   (pk_req),
        .last  (pk_last),
        .valid (pk_valid),
        .idx   (pk_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic [2:0] s,
                           input logic b, input logic t);
        chk({tag, ".grant"}, {4'd0, grant}, {4'd0, g});
        chk({tag, ".select"}, {5'd0, select}, {5'd0, s});
        chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
        chk({tag, ".timeout"}, {7'd0, timeout}, {7'd0, t});
    endtask

    initial begin
        logic       exp_valid;
        logic [1:0] exp_idx;
        logic [1:0] cand;
        int         seq [5];

        rst = 1'b0;
        req = 4'b1111;
        done = 4'd0;
        buttons = 3'd0;

        // Picker alone over all 64 combinations.
        for (int l = 0; l < 4; l++) begin
            for (int r = 0; r < 16; r++) begin
                pk_last = 2'(l);
                pk_req  = 4'(r);
                #1;
                exp_valid = 1'b0;
                exp_idx   = 2'(l + 1);
                for (int off = 4; off >= 1; off--) begin
                    cand = 2'((l + off) % 4);
                    if (pk_req[cand]) begin
                        exp_valid = 1'b1;
                        exp_idx   = cand;
                    end
                end
                chk($sformatf("pick.valid l=%0d r=%0h", l, r), {7'd0, pk_valid}, {7'd0, exp_valid});
                if (exp_valid)
                    chk($sformatf("pick.idx l=%0d r=%0h", l, r), {6'd0, pk_idx}, {6'd0, exp_idx});
                $display("pick last=%0d req=%b -> valid=%0b idx=%0d", l, pk_req, pk_valid, pk_idx);
            end
        end

        // Reset held with all requests asserted.
        tick();
        tick();
        chk_out("reset", 4'd0, 3'd0, 1'b0, 1'b0);
        chk("reset.btn_out", {5'd0, btn_out}, 8'd0);
        $display("reset held: select=%0d grant=%b", select, grant);
        rst = 1'b1;
        tick();
        chk_out("first_grant", 4'b0001, 3'd1, 1'b1, 1'b0);
        $display("release: select=%0d grant=%b", select, grant);

        // All four requesting, no done: 4-cycle turns, timeout each turn, 2-cycle gap.
        seq = '{0, 1, 2, 3, 0};
        for (int t = 0; t < 5; t++) begin
            for (int k = 0; k < 4; k++) begin
                chk_out($sformatf("rr.turn%0d.cyc%0d", t, k), 4'b0001 << seq[t],
                        3'(seq[t] + 1), 1'b1, 1'b0);
                tick();
            end
            chk_out($sformatf("rr.turn%0d.gap", t), 4'd0, 3'd0, 1'b0, 1'b1);
            tick();
            chk_out($sformatf("rr.turn%0d.idle", t), 4'd0, 3'd0, 1'b0, 1'b0);
            tick();
            $display("turn %0d channel %0d completed by timeout", t, seq[t]);
        end
        // Channel 1 now holds; withdraw everything.
        chk_out("rr.next", 4'b0010, 3'd2, 1'b1, 1'b0);
        req = 4'd0;
        tick();
        chk_out("withdraw_all", 4'd0, 3'd0, 1'b0, 1'b0);
        tick();
        tick();

        // Channel 2 alone, done[2] on its 3rd cycle, done[0] ignored.
        req = 4'b0100;
        tick();
        chk_out("done.cyc1", 4'b0100, 3'd3, 1'b1, 1'b0);
        tick();
        done = 4'b0001;
        chk_out("done.cyc2", 4'b0100, 3'd3, 1'b1, 1'b0);
        tick();
        done = 4'b0100;
        chk_out("done.cyc3", 4'b0100, 3'd3, 1'b1, 1'b0);
        tick();
        chk_out("done.end", 4'd0, 3'd0, 1'b0, 1'b0);
        $display("channel 2 ended by done after 3 cycles, timeout=%0b", timeout);
        done = 4'd0;
        req = 4'd0;
        tick();
        tick();

        // Channel 1 drops its request mid-turn while buttons=101; channel 2 waiting.
        req = 4'b0110;
        buttons = 3'b101;
        tick();
        chk_out("wd.cyc1", 4'b0010, 3'd2, 1'b1, 1'b0);
        chk("wd.btn_cyc1", {5'd0, btn_out}, 8'd0);
        tick();
        chk("wd.btn_cyc2", {5'd0, btn_out}, 8'h05);
        req = 4'b0100;
        tick();
        chk_out("wd.end", 4'd0, 3'd0, 1'b0, 1'b0);
        chk("wd.btn_end", {5'd0, btn_out}, 8'd0);
        tick();
        chk("wd.idle_sel", {5'd0, select}, 8'd0);
        tick();
        chk_out("wd.next", 4'b0100, 3'd3, 1'b1, 1'b0);
        chk("wd.next_btn", {5'd0, btn_out}, 8'd0);
        $display("channel 1 withdrew, next grant channel %0d", select - 3'd1);

        // done coincident with the final counter cycle: no timeout.
        tick();
        tick();
        tick();
        chk_out("last.cyc4", 4'b0100, 3'd3, 1'b1, 1'b0);
        done = 4'b0100;
        tick();
        chk_out("last.end", 4'd0, 3'd0, 1'b0, 1'b0);
        $display("done on final cycle: timeout=%0b", timeout);
        done = 4'd0;
        req = 4'd0;
        tick();
        tick();

        // Asynchronous reset mid-grant.
        req = 4'b1000;
        tick();
        chk_out("arst.grant", 4'b1000, 3'd4, 1'b1, 1'b0);
        tick();
        #2 rst = 1'b0;
        #1;
        chk_out("arst.async", 4'd0, 3'd0, 1'b0, 1'b0);
        chk("arst.btn_out", {5'd0, btn_out}, 8'd0);
        $display("async reset mid-grant: grant=%b select=%0d", grant, select);
        req = 4'b1111;
        @(negedge clk);
        rst = 1'b1;
        tick();
        chk_out("arst.restart", 4'b0001, 3'd1, 1'b1, 1'b0);
        $display("after reset release: select=%0d grant=%b", select, grant);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
